// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI target endpoint.
//   state_t        : target FSM states (IDLE between frames, ACTIVE while selected)
//   SPI_DATA_W     : default word width
//   SPI_IDLE_LEVEL : fill bit for the word sent when no transmit data is buffered
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  // The idle word is built from this bit at whatever width the top uses,
  // so it is all ones for any DATA_W.
  localparam logic SPI_IDLE_LEVEL = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
// Brings one asynchronous SPI pin into the clk domain through a chain of
// SYNC_STAGES flops and flags its edges by comparing the synchronized level
// against one further registered copy.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : asynchronous input pin
//   level      : synchronized level
//   rise, fall : single-cycle edge flags on the synchronized level
// ---------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // The reset value matches the pin's idle level so that releasing reset
  // never produces a spurious edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_target_port.sv
// ---------------------------------------------------------------------------
// spi_target_port
// SPI target endpoint, mode 0 (CPOL=0, CPHA=0), MSB first, DATA_W-bit words.
// SCK, MOSI and CS_N are oversampled by clk (at least 8x SCK). Each received
// word is presented on rx_data with a one-cycle rx_valid. Transmit words come
// from a one-entry holding buffer written through a valid/ready handshake;
// a word that starts with the buffer empty sends all ones and flags underrun.
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   sck_i        : SPI clock from the master (asynchronous)
//   mosi_i       : SPI data from the master (asynchronous)
//   cs_n_i       : chip select, active low (asynchronous)
//   miso_o       : SPI data to the master
//   miso_oe      : MISO output enable, high while selected
//   rx_data      : last complete received word
//   rx_valid     : one-cycle pulse when rx_data updates
//   tx_data      : next word to send
//   tx_valid     : tx_data offered
//   tx_ready     : holding buffer empty
//   tx_underrun  : one-cycle pulse when a word starts with the buffer empty
//   frame_end    : one-cycle pulse when the frame is closed by CS_N rising
// ---------------------------------------------------------------------------
module spi_target_port
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck_i,
  input  logic              mosi_i,
  input  logic              cs_n_i,
  output logic              miso_o,
  output logic              miso_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic              frame_end
);

  localparam int                CNT_W         = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT      = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] SPI_IDLE_WORD = {DATA_W{SPI_IDLE_LEVEL}};

  logic sck_lvl, sck_rise, sck_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic cs_lvl, cs_rise, cs_fall;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] buf_data;
  logic              buf_full;

  logic do_load, do_rx, do_tx, do_end;
  logic buf_write;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sck_i),
    .level (sck_lvl),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (mosi_i),
    .level (mosi_lvl),
    .rise  (mosi_rise),
    .fall  (mosi_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (cs_n_i),
    .level (cs_lvl),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // Only the MOSI level and the SCK/CS edges drive the design.
  logic unused_sync_outputs;
  assign unused_sync_outputs = ^{mosi_rise, mosi_fall, sck_lvl, cs_lvl};

  assign tx_ready  = ~buf_full;
  assign buf_write = tx_valid & ~buf_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // CS edges take priority over an SCK edge seen in the same cycle; SCK
  // edges while deselected are ignored. A falling SCK with bit_cnt at zero
  // marks the start of the next word rather than a bit shift.
  always_comb begin
    state_d = state_q;
    do_load = 1'b0;
    do_rx   = 1'b0;
    do_tx   = 1'b0;
    do_end  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          do_load = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          do_end  = 1'b1;
        end else if (sck_rise) begin
          do_rx = 1'b1;
        end else if (sck_fall) begin
          if (bit_cnt == '0) do_load = 1'b1;
          else               do_tx   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath. A load sees the buffer as it was at the start of the cycle:
  // with the buffer empty it underruns even if a write lands in the same
  // cycle, and that written word then waits for the following load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      buf_data    <= '0;
      buf_full    <= 1'b0;
      miso_o      <= 1'b0;
      miso_oe     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_end   <= 1'b0;

      if (buf_write) begin
        buf_data <= tx_data;
        buf_full <= 1'b1;
      end

      if (do_load) begin
        if (buf_full) begin
          tx_shift <= buf_data;
          miso_o   <= buf_data[DATA_W-1];
          buf_full <= 1'b0;
        end else begin
          tx_shift    <= SPI_IDLE_WORD;
          miso_o      <= SPI_IDLE_LEVEL;
          tx_underrun <= 1'b1;
        end
        bit_cnt <= '0;
        miso_oe <= 1'b1;
      end

      if (do_rx) begin
        rx_shift <= {rx_shift[DATA_W-2:0], mosi_lvl};
        if (bit_cnt == LAST_BIT) begin
          bit_cnt  <= '0;
          rx_data  <= {rx_shift[DATA_W-2:0], mosi_lvl};
          rx_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end

      if (do_tx) begin
        miso_o   <= tx_shift[DATA_W-2];
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end

      // Any partial word in either direction is simply abandoned.
      if (do_end) begin
        bit_cnt   <= '0;
        miso_oe   <= 1'b0;
        miso_o    <= 1'b0;
        frame_end <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_target_port.sv
// ---------------------------------------------------------------------------
// tb_spi_target_port
// Drives spi_target_port as a mode-0 SPI master at clk/8 and compares the
// received words, the MISO words, the underrun and frame-end pulse counts and
// the handshake against a word-level model of the holding buffer.
// ---------------------------------------------------------------------------
module tb_spi_target_port;

  localparam int DATA_W = 8;
  localparam int HALF   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sck = 1'b0;
  logic              mosi = 1'b0;
  logic              cs_n = 1'b1;
  logic              miso_o;
  logic              miso_oe;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_valid = 1'b0;
  logic              tx_ready;
  logic              tx_underrun;
  logic              frame_end;

  int errors = 0;
  int checks = 0;

  logic [7:0] rx_q[$];
  int underrun_cnt = 0;
  int frame_end_cnt = 0;
  int rv_run = 0, fe_run = 0, max_rv_run = 0, max_fe_run = 0;

  logic [7:0] mosi_words[$];
  logic [7:0] miso_words[$];

  // Word-level model of the holding buffer.
  logic       model_full = 1'b0;
  logic [7:0] model_buf = '0;

  spi_target_port #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sck_i       (sck),
    .mosi_i      (mosi),
    .cs_n_i      (cs_n),
    .miso_o      (miso_o),
    .miso_oe     (miso_oe),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_underrun (tx_underrun),
    .frame_end   (frame_end)
  );

  always #5 clk = ~clk;

  // Pulse monitor: collects received words and counts strobes, sampled on
  // the inactive clock edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        rx_q.push_back(rx_data);
        rv_run = rv_run + 1;
        if (rv_run > max_rv_run) max_rv_run = rv_run;
      end else begin
        rv_run = 0;
      end
      if (frame_end) begin
        frame_end_cnt = frame_end_cnt + 1;
        fe_run = fe_run + 1;
        if (fe_run > max_fe_run) max_fe_run = fe_run;
      end else begin
        fe_run = 0;
      end
      if (tx_underrun) underrun_cnt = underrun_cnt + 1;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic offer_tx(input logic [7:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tx_ready_before_write", {31'd0, tx_ready}, 32'd1);
    tx_data  = w;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    model_buf  = w;
    model_full = 1'b1;
    @(negedge clk);
    checkOutput("tx_ready_after_write", {31'd0, tx_ready}, 32'd0);
  endtask

  // Master side of one frame. mode 0: complete, mode 1: CS_N rises after
  // 'bits' bits, mode 2: rst_n asserted after 'bits' bits. The last SCK fall
  // and the CS_N rise are driven together, as a master releasing select.
  task automatic applyStimulus(input int mode, input int bits, input bit cs_low);
    logic [7:0] acc;
    logic [7:0] cur;
    miso_words.delete();
    acc = '0;
    if (!cs_low) begin
      @(posedge clk);
      #1 cs_n = 1'b0;
    end
    repeat (8) @(posedge clk);
    #1;
    checkOutput("miso_oe_selected", {31'd0, miso_oe}, 32'd1);
    for (int b = 0; b < bits; b++) begin
      cur  = mosi_words[b / 8];
      mosi = cur[7 - (b % 8)];
      repeat (HALF) @(posedge clk);
      #1;
      acc = {acc[6:0], miso_o};
      sck = 1'b1;
      if (b % 8 == 7) miso_words.push_back(acc);
      repeat (HALF) @(posedge clk);
      #1;
      if (b == bits - 1 && mode == 2) begin
        rst_n = 1'b0;
        sck   = 1'b0;
        cs_n  = 1'b1;
        mosi  = 1'b0;
        #1;
        checkOutput("async_reset_miso_oe", {31'd0, miso_oe}, 32'd0);
        checkOutput("async_reset_miso", {31'd0, miso_o}, 32'd0);
        checkOutput("async_reset_tx_ready", {31'd0, tx_ready}, 32'd1);
        checkOutput("async_reset_rx_data", {24'd0, rx_data}, 32'd0);
        checkOutput("async_reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
      end else begin
        sck = 1'b0;
        if (b == bits - 1) cs_n = 1'b1;
      end
    end
    repeat (8) @(posedge clk);
    #1 mosi = 1'b0;
  endtask

  // Runs one frame of mosi_words and checks it against the buffer model:
  // every word start takes the buffered word if there is one, else sends
  // 0xFF and counts an underrun.
  task automatic run_frame(input int mode, input int bits_limit,
                           input bit late_write, input logic [7:0] late_word);
    int n, bits, full_words, started, ur0, fe0, exp_ur;
    logic [7:0] pending[$];
    logic [7:0] exp_miso[$];
    n          = mosi_words.size();
    bits       = (mode == 0) ? n * 8 : bits_limit;
    full_words = bits / 8;
    started    = (bits + 7) / 8;
    exp_ur     = 0;
    if (model_full) pending.push_back(model_buf);
    for (int k = 0; k < started; k++) begin
      if (pending.size() > 0) begin
        exp_miso.push_back(pending.pop_front());
      end else begin
        exp_miso.push_back(8'hFF);
        exp_ur++;
      end
      if (k == 0 && late_write) pending.push_back(late_word);
    end
    model_full = (pending.size() > 0) && (mode != 2);
    if (model_full) model_buf = pending[0];

    rx_q.delete();
    ur0 = underrun_cnt;
    fe0 = frame_end_cnt;

    if (late_write) begin
      @(posedge clk);
      #1 cs_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      tx_data  = late_word;
      tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
      @(negedge clk);
      checkOutput("late_write_underrun", {31'd0, tx_underrun}, 32'd1);
      checkOutput("late_write_tx_ready", {31'd0, tx_ready}, 32'd0);
      applyStimulus(mode, bits, 1'b1);
    end else begin
      applyStimulus(mode, bits, 1'b0);
    end

    checkOutput("rx_count", rx_q.size(), (mode == 2) ? 0 : full_words);
    for (int k = 0; k < full_words && k < rx_q.size(); k++)
      checkOutput("rx_word", {24'd0, rx_q[k]}, {24'd0, mosi_words[k]});
    checkOutput("miso_count", miso_words.size(), full_words);
    for (int k = 0; k < full_words && k < miso_words.size(); k++)
      checkOutput("miso_word", {24'd0, miso_words[k]}, {24'd0, exp_miso[k]});
    checkOutput("underrun_pulses", underrun_cnt - ur0, exp_ur);
    checkOutput("frame_end_pulses", frame_end_cnt - fe0, (mode == 2) ? 0 : 1);
    checkOutput("tx_ready_after_frame", {31'd0, tx_ready}, {31'd0, !model_full});
    checkOutput("miso_oe_after_frame", {31'd0, miso_oe}, 32'd0);
  endtask

  initial begin
    int nw;
    int mode;
    int bits;
    bit late;
    logic [7:0] w;

    // Reset state, checked while reset is held and again after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_miso", {31'd0, miso_o}, 32'd0);
    checkOutput("reset_miso_oe", {31'd0, miso_oe}, 32'd0);
    checkOutput("reset_rx_data", {24'd0, rx_data}, 32'd0);
    checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("reset_tx_underrun", {31'd0, tx_underrun}, 32'd0);
    checkOutput("reset_frame_end", {31'd0, frame_end}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("idle_miso_oe", {31'd0, miso_oe}, 32'd0);
    checkOutput("idle_tx_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("idle_frame_end_count", frame_end_cnt, 0);

    $display("[TB] preloaded single word");
    offer_tx(8'h3C);
    mosi_words = '{8'hA5};
    run_frame(0, 0, 1'b0, 8'h00);

    $display("[TB] two words, one buffered");
    offer_tx(8'hC3);
    mosi_words = '{8'h12, 8'h34};
    run_frame(0, 0, 1'b0, 8'h00);

    $display("[TB] abort after five bits, then a full frame");
    mosi_words = '{8'hE7};
    run_frame(1, 5, 1'b0, 8'h00);
    mosi_words = '{8'h5A};
    run_frame(0, 0, 1'b0, 8'h00);

    $display("[TB] write in the load cycle of an empty buffer");
    mosi_words = '{8'h11, 8'h22};
    run_frame(0, 0, 1'b1, 8'h81);

    $display("[TB] reset mid-frame, then a full frame");
    offer_tx(8'h99);
    mosi_words = '{8'hF0};
    run_frame(2, 4, 1'b0, 8'h00);
    mosi_words = '{8'h7E};
    run_frame(0, 0, 1'b0, 8'h00);

    $display("[TB] randomized frames");
    for (int f = 0; f < 8; f++) begin
      nw = $urandom_range(3, 1);
      mosi_words.delete();
      for (int k = 0; k < nw; k++) begin
        w = 8'($urandom);
        mosi_words.push_back(w);
      end
      if (!model_full && ($urandom_range(1, 0) == 1)) offer_tx(8'($urandom));
      late = !model_full && ($urandom_range(3, 0) == 0);
      mode = ($urandom_range(4, 0) == 0) ? 1 : 0;
      bits = (mode == 1) ? $urandom_range(nw * 8 - 1, 1) : 0;
      run_frame(mode, bits, late, 8'($urandom));
    end

    checkOutput("rx_valid_width", {31'd0, max_rv_run <= 1}, 32'd1);
    checkOutput("frame_end_width", {31'd0, max_fe_run <= 1}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
